// File: rtl/cache_mem_pkg.sv
// Shared types and helpers for the main-memory port of the cache.
package cache_mem_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_WAIT  = 3'd1,
        WR_ACK   = 3'd2,
        RD_WAIT  = 3'd3,
        RD_VALID = 3'd4
    } mem_state_t;

    // Width of the latency counter that must hold max(rd, wr) latency - 1.
    function automatic int MEM_CNT_W(input int rd_latency, input int wr_latency);
        int m;
        m = (rd_latency > wr_latency) ? rd_latency : wr_latency;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/cache_mem_port_if.sv
// Handshake bundle between the cache controller (master) and main memory (slave).
interface cache_mem_port_if #(
    parameter int BLOCK_WIDTH = 128,
    parameter int MEM_DEPTH   = 1024
);
    localparam int ADDR_W = $clog2(MEM_DEPTH);

    logic                   read_en_mem;
    logic                   write_en_mem;
    logic                   valid_cache;
    logic                   ready_cache;
    logic [ADDR_W-1:0]      addr;
    logic [BLOCK_WIDTH-1:0] wdata;
    logic                   ready_mem;
    logic                   valid_mem;
    logic [BLOCK_WIDTH-1:0] rdata;
    logic                   busy;

    modport master (
        output read_en_mem, write_en_mem, valid_cache, ready_cache, addr, wdata,
        input  ready_mem, valid_mem, rdata, busy
    );

    modport slave (
        input  read_en_mem, write_en_mem, valid_cache, ready_cache, addr, wdata,
        output ready_mem, valid_mem, rdata, busy
    );

endinterface

// File: rtl/cache_mem_port_latency_timer.sv
// Load/decrement down-counter with zero flag; one instance serves both read and write waits.
module mem_latency_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/cache_mem_port.sv
// Block-wide backing store with programmable read/write latency behind the cache controller.
// Optional access counters (rd_count, wr_count) are enabled with `define CACHE_MEM_STATS_EN.
module cache_mem_port
    import cache_mem_pkg::*;
#(
    parameter int BLOCK_WIDTH = 128,
    parameter int MEM_DEPTH   = 1024,
    parameter int RD_LATENCY  = 4,
    parameter int WR_LATENCY  = 2
) (
    input  logic            clk,
    input  logic            rst,
`ifdef CACHE_MEM_STATS_EN
    output logic [31:0]     rd_count,
    output logic [31:0]     wr_count,
`endif
    cache_mem_port_if.slave bus
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam int CNT_W  = MEM_CNT_W(RD_LATENCY, WR_LATENCY);

    mem_state_t             state, state_next;
    logic                   tmr_load;
    logic [CNT_W-1:0]       tmr_load_val;
    logic                   tmr_dec;
    logic [CNT_W-1:0]       cnt;
    logic                   cnt_zero;
    logic                   wr_commit;
    logic                   rd_load;
    logic                   rd_done;
    logic [BLOCK_WIDTH-1:0] rdata_q;
    logic [BLOCK_WIDTH-1:0] mem [MEM_DEPTH];

    mem_latency_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        wr_commit    = 1'b0;
        rd_load      = 1'b0;
        rd_done      = 1'b0;
        unique case (state)
            IDLE: begin
                // Write-back is serviced before refill on a dirty miss.
                if (bus.valid_cache) begin
                    state_next   = WR_WAIT;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(WR_LATENCY - 1);
                end else if (bus.read_en_mem) begin
                    state_next   = RD_WAIT;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(RD_LATENCY - 1);
                end
            end
            WR_WAIT: begin
                if (!bus.valid_cache) begin
                    state_next = IDLE;
                end else if (cnt_zero) begin
                    state_next = WR_ACK;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            WR_ACK: begin
                if (bus.valid_cache && bus.write_en_mem) begin
                    wr_commit  = 1'b1;
                    state_next = IDLE;
                end else if (!bus.valid_cache) begin
                    state_next = IDLE;
                end
            end
            RD_WAIT: begin
                if (!bus.read_en_mem) begin
                    state_next = IDLE;
                end else if (cnt_zero) begin
                    rd_load    = 1'b1;
                    state_next = RD_VALID;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            RD_VALID: begin
                if (bus.ready_cache) begin
                    rd_done    = 1'b1;
                    state_next = IDLE;
                end else if (!bus.read_en_mem) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Storage is not reset; a reset forces state to IDLE so no commit can follow it.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem[bus.addr] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_load) begin
            rdata_q <= mem[bus.addr];
        end
    end

    assign bus.ready_mem = (state == WR_ACK);
    assign bus.valid_mem = (state == RD_VALID);
    assign bus.busy      = (state != IDLE);
    assign bus.rdata     = rdata_q;

`ifdef CACHE_MEM_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_done) begin
                rd_count <= rd_count + 32'd1;
            end
            if (wr_commit) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_mem_port.sv
// Scoreboard bench for cache_mem_port: write-backs, refills, backpressure, aborts and reset.
module tb_cache_mem_port;

    localparam int BW  = 128;
    localparam int MD  = 1024;
    localparam int RDL = 4;
    localparam int WRL = 2;
    localparam int AW  = $clog2(MD);

    logic clk;
    logic rst;
`ifdef CACHE_MEM_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    cache_mem_port_if #(.BLOCK_WIDTH(BW), .MEM_DEPTH(MD)) bus ();

    cache_mem_port #(
        .BLOCK_WIDTH (BW),
        .MEM_DEPTH   (MD),
        .RD_LATENCY  (RDL),
        .WR_LATENCY  (WRL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef CACHE_MEM_STATS_EN
        .rd_count (rd_count),
        .wr_count (wr_count),
`endif
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int exp_rd = 0;
    int exp_wr = 0;
    logic [BW-1:0] sb[$];
    logic [BW-1:0] model [int];

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Completed refills are checked against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.valid_mem && bus.ready_cache) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                chk("sb_rdata", bus.rdata, sb.pop_front());
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [BW-1:0] d, input int we_delay);
        bus.valid_cache  = 1'b1;
        bus.write_en_mem = 1'b0;
        bus.addr         = a;
        bus.wdata        = d;
        repeat (WRL) begin
            tick();
            chk("wr_wait_ready", bus.ready_mem, 0);
            chk("wr_wait_valid", bus.valid_mem, 0);
        end
        tick();
        chk("wr_ack_ready", bus.ready_mem, 1);
        chk("wr_ack_busy", bus.busy, 1);
        repeat (we_delay) begin
            tick();
            chk("wr_ack_hold", bus.ready_mem, 1);
        end
        bus.write_en_mem = 1'b1;
        tick();
        chk("wr_done_busy", bus.busy, 0);
        chk("wr_done_ready", bus.ready_mem, 0);
        chk("wr_done_valid", bus.valid_mem, 0);
        bus.valid_cache  = 1'b0;
        bus.write_en_mem = 1'b0;
        model[int'(a)]   = d;
        exp_wr++;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int bp);
        logic [BW-1:0] exp;
        exp = model[int'(a)];
        sb.push_back(exp);
        bus.addr        = a;
        bus.read_en_mem = 1'b1;
        bus.ready_cache = (bp == 0);
        repeat (RDL) begin
            tick();
            chk("rd_wait_valid", bus.valid_mem, 0);
            chk("rd_wait_busy", bus.busy, 1);
        end
        tick();
        chk("rd_valid_rise", bus.valid_mem, 1);
        chk("rd_data", bus.rdata, exp);
        for (int i = 1; i < bp; i++) begin
            tick();
            chk("bp_valid", bus.valid_mem, 1);
            chk("bp_rdata", bus.rdata, exp);
        end
        bus.ready_cache = 1'b1;
        tick();
        chk("rd_done_busy", bus.busy, 0);
        chk("rd_done_valid", bus.valid_mem, 0);
        bus.read_en_mem = 1'b0;
        bus.ready_cache = 1'b0;
        exp_rd++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] d_a5;
        logic [BW-1:0] d_12;
        logic [BW-1:0] d_x;
        d_a5 = {16{8'hA5}};
        d_12 = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
        d_x  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

        rst              = 1'b1;
        bus.read_en_mem  = 1'b0;
        bus.write_en_mem = 1'b0;
        bus.valid_cache  = 1'b0;
        bus.ready_cache  = 1'b0;
        bus.addr         = '0;
        bus.wdata        = '0;
        #1;
        chk("rst_ready", bus.ready_mem, 0);
        chk("rst_valid", bus.valid_mem, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rdata", bus.rdata, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Clean refill of a preloaded block.
        do_write(10'd5, d_a5, 0);
        do_read(10'd5, 0);

        // Dirty miss: write-back with a late strobe, then back-to-back refill.
        do_write(10'd9, d_12, 2);
        do_read(10'd9, 0);

        // Backpressure for three cycles.
        do_read(10'd5, 3);

        // Simultaneous write-back and refill request: write wins, read follows.
        bus.read_en_mem = 1'b1;
        bus.ready_cache = 1'b1;
        do_write(10'd17, d_x, 1);
        do_read(10'd17, 0);

        // Read aborted in RD_WAIT.
        bus.addr        = 10'd5;
        bus.read_en_mem = 1'b1;
        bus.ready_cache = 1'b1;
        repeat (2) tick();
        chk("abort_busy_wait", bus.busy, 1);
        bus.read_en_mem = 1'b0;
        tick();
        chk("abort_busy", bus.busy, 0);
        repeat (RDL + 1) begin
            tick();
            chk("abort_valid", bus.valid_mem, 0);
        end
        bus.ready_cache = 1'b0;

        // Reset asserted in WR_ACK with the write strobe up: no commit.
        bus.valid_cache  = 1'b1;
        bus.addr         = 10'd9;
        bus.wdata        = d_x;
        repeat (WRL + 1) tick();
        chk("rst_wr_ack", bus.ready_mem, 1);
        bus.write_en_mem = 1'b1;
        rst              = 1'b1;
        #1;
        chk("rst_mid_ready", bus.ready_mem, 0);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_valid", bus.valid_mem, 0);
        chk("rst_mid_rdata", bus.rdata, 0);
        tick();
        bus.valid_cache  = 1'b0;
        bus.write_en_mem = 1'b0;
        rst              = 1'b0;
        tick();
        do_read(10'd9, 0);

`ifdef CACHE_MEM_STATS_EN
        chk("stat_rd", {96'd0, rd_count}, BW'(exp_rd));
        chk("stat_wr", {96'd0, wr_count}, BW'(exp_wr));
`endif
        repeat (2) tick();
        chk("sb_empty", BW'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_mem_port.md
# cache_mem_port

Main-memory side of the cache: a block-wide backing store with programmable read and write latency. It answers the cache controller's write-back and refill handshakes. It sits directly downstream of the cache controller and consumes its `read_en_mem`, `write_en_mem`, `valid_cache` and `ready_cache` outputs. It drives the controller's `ready_mem` and `valid_mem` inputs and returns refill data to the cache data array.

## Interface
- `BLOCK_WIDTH`, 128: bits per cache block and per transfer.
- `MEM_DEPTH`, 1024: number of blocks in the store; must be a power of two.
- `RD_LATENCY`, 4: wait cycles before refill data is offered; ≥1.
- `WR_LATENCY`, 2: wait cycles before a write-back is accepted; ≥1.
- `clk` input, 1: clock.
- `rst` input, 1: reset, asynchronous, active-high.
- `read_en_mem` input, 1: refill request from the controller.
- `write_en_mem` input, 1: write strobe from the controller, qualified by `ready_mem`.
- `valid_cache` input, 1: the cache presents a write-back block.
- `ready_cache` input, 1: the cache can accept refill data.
- `addr` input, $clog2(MEM_DEPTH): block index. Held stable by the datapath for the whole transaction.
- `wdata` input, BLOCK_WIDTH: write-back block.
- `ready_mem` output, 1: the memory accepts the write-back this cycle.
- `valid_mem` output, 1: `rdata` holds a valid refill block.
- `rdata` output, BLOCK_WIDTH: refill block, registered.
- `busy` output, 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, WR_WAIT, WR_ACK, RD_WAIT, RD_VALID. There is one latency counter `cnt`.
- **IDLE:**
  - If `valid_cache`=1, go to WR_WAIT with `cnt`←WR_LATENCY-1.
  - Otherwise, if `read_en_mem`=1, go to RD_WAIT with `cnt`←RD_LATENCY-1.
  - When both are high, the write wins, because write-back always precedes refill.
- **WR_WAIT:**
  - If `valid_cache`=0, abort to IDLE with no write.
  - Otherwise, if `cnt`=0, go to WR_ACK.
  - Otherwise decrement `cnt`.
- **WR_ACK:**
  - `ready_mem`=1.
  - If `valid_cache` && `write_en_mem`, then `mem[addr]`←`wdata` at the edge, and go to IDLE.
  - If `valid_cache`=0, go to IDLE with no write.
  - Otherwise stay in WR_ACK.
- **RD_WAIT:**
  - If `read_en_mem`=0, abort to IDLE.
  - Otherwise, if `cnt`=0, load `rdata`←`mem[addr]` and go to RD_VALID.
  - Otherwise decrement `cnt`.
- **RD_VALID:**
  - `valid_mem`=1, and `rdata` is held stable.
  - If `ready_cache`=1, complete the transfer and go to IDLE.
  - If `read_en_mem`=0 with `ready_cache`=0, abort to IDLE.
- `ready_mem` is 0 in every state except WR_ACK. The memory is busy while sending refill data.
- `valid_mem` is 1 only in RD_VALID.
- Storage contents are not reset. A read of a never-written block returns X in simulation.
- `cnt` width is $clog2(max(RD_LATENCY, WR_LATENCY))+1. It never underflows: decrement happens only when `cnt`≠0.
- An address beyond MEM_DEPTH cannot occur, because the index width is exact.

## Timing
- **Reset values:** state=IDLE, `cnt`=0, `ready_mem`=0, `valid_mem`=0, `rdata`=0, `busy`=0. Reset during any transaction returns to IDLE immediately, with no partial write.
- **Write:** if `valid_cache` is first sampled high in IDLE at cycle 0, `ready_mem` rises in cycle WR_LATENCY+1. The write commits at the end of the first WR_ACK cycle in which `write_en_mem`=1. `busy` falls the next cycle.
- **Read:** if `read_en_mem` is first sampled in IDLE at cycle 0, `valid_mem` rises in cycle RD_LATENCY+1. It stays high until the cycle in which `ready_cache`=1, inclusive.
- **Back-to-back:** a refill request may be sampled in the IDLE cycle immediately after a write-back completes. The minimum dirty-miss service time is (WR_LATENCY+2)+(RD_LATENCY+2) cycles.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to `ready_mem` or `valid_mem`.

## Configuration
- Macro `CACHE_MEM_STATS_EN`.
- **Defined:** adds outputs `rd_count` and `wr_count`, 32 bits each, reset to 0.
  - `rd_count` increments on each completed refill, i.e. `valid_mem` && `ready_cache`.
  - `wr_count` increments on each committed write.
  - Both wrap modulo 2^32.
  - Aborted transactions are not counted.
- **Undefined:** the ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- Package `cache_mem_pkg` holds:
  - `mem_state_t`, the 3-bit enum of the five states;
  - a `MEM_CNT_W` helper function.
- Sub-module `mem_latency_timer` is the load/decrement/zero-flag counter, parameterised by width. It is instantiated once, shared by the read and write paths.
- The storage array is inferred inside `cache_mem_port`.

## Test plan
Parameters for all scenarios: RD_LATENCY=4, WR_LATENCY=2, BLOCK_WIDTH=128.
1. Clean refill: `addr`=5 is preloaded with 0xA5…A5, and `read_en_mem` is held with `ready_cache`=1 -> `valid_mem` rises 5 cycles after the request and `rdata`=0xA5…A5. The transfer completes in that cycle, and `busy`=0 next.
2. Dirty miss: `valid_cache`=1 with `wdata`=0x1234…, `addr`=9, and `write_en_mem` is asserted when `ready_mem`=1 -> `ready_mem` rises at cycle 3. Then a read of `addr`=9 returns 0x1234… after 5 further cycles.
3. Backpressure: `valid_mem`=1 with `ready_cache`=0 for 3 cycles -> `valid_mem` and `rdata` stay stable, and the transfer completes on the first `ready_cache`=1.
4. Simultaneous: `valid_cache` and `read_en_mem` are both high in IDLE -> the FSM enters WR_WAIT, and `valid_mem` stays 0 until the write completes.
5. Abort and reset: `read_en_mem` drops in RD_WAIT -> IDLE with no `valid_mem`. `rst` asserted in WR_ACK -> all outputs return to reset values, and `mem[addr]` is unchanged.
6. With `CACHE_MEM_STATS_EN`: 3 refills, 2 writes and 1 aborted read -> `rd_count`=3, `wr_count`=2.
